// File: rtl/mux2_rr_arbiter.sv
// Two-source select-and-register stage with a round-robin, burst-limited arbiter.
// The winning word is captured into a single output register that is drained by valid/ready.
module mux2_rr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i0_valid,
  input  logic [WIDTH-1:0] i0_data,
  output logic             i0_ready,
  input  logic             i1_valid,
  input  logic [WIDTH-1:0] i1_data,
  output logic             i1_ready,
  output logic             sel,
  output logic             y_valid,
  output logic [WIDTH-1:0] y,
  input  logic             y_ready
);

  localparam int CW = $clog2(BURST + 1);
  localparam logic [CW-1:0] CMAX = CW'(BURST);

  logic          last;
  logic [CW-1:0] burst_cnt;
  logic [CW-1:0] cnt_nxt;
  logic          load_en;
  logic          any_v;
  logic          rotate;
  logic          grant;
  logic          xfer;

  always_comb begin
    load_en = !y_valid | y_ready;
    any_v   = i0_valid | i1_valid;
    // an idle gap or an exhausted burst hands priority to the other side
    rotate  = (burst_cnt == '0) | (burst_cnt == CMAX);
    grant   = 1'b0;
    unique case (1'b1)
      (i0_valid & !i1_valid): grant = 1'b0;
      (!i0_valid & i1_valid): grant = 1'b1;
      (i0_valid & i1_valid):  grant = rotate ? ~last : last;
      default:                grant = 1'b0;
    endcase
    xfer     = load_en & any_v & !rst;
    i0_ready = xfer & !grant & i0_valid;
    i1_ready = xfer & grant & i1_valid;
    cnt_nxt  = CW'(1);
    if (grant == last && burst_cnt != '0)
      cnt_nxt = (burst_cnt == CMAX) ? CMAX : burst_cnt + CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      y_valid   <= 1'b0;
      y         <= '0;
      sel       <= 1'b0;
      last      <= 1'b1;
      burst_cnt <= '0;
    end else if (load_en) begin
      if (any_v) begin
        y         <= grant ? i1_data : i0_data;
        sel       <= grant;
        y_valid   <= 1'b1;
        last      <= grant;
        burst_cnt <= cnt_nxt;
      end else begin
        y_valid   <= y_valid & ~y_ready;
        burst_cnt <= '0;
      end
    end
  end

endmodule

// File: tb/tb_mux2_rr_arbiter.sv
// Bench for mux2_rr_arbiter: directed scenarios plus randomized traffic
// compared against a behavioural model of the arbitration rules.
module tb_mux2_rr_arbiter;

  localparam int WIDTH = 8;
  localparam int BURST = 2;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic             i0_valid = 1'b0;
  logic [WIDTH-1:0] i0_data = '0;
  logic             i0_ready;
  logic             i1_valid = 1'b0;
  logic [WIDTH-1:0] i1_data = '0;
  logic             i1_ready;
  logic             sel;
  logic             y_valid;
  logic [WIDTH-1:0] y;
  logic             y_ready = 1'b0;

  int checks = 0;
  int errors = 0;

  mux2_rr_arbiter #(.WIDTH(WIDTH), .BURST(BURST)) dut (
    .clk(clk), .rst(rst),
    .i0_valid(i0_valid), .i0_data(i0_data), .i0_ready(i0_ready),
    .i1_valid(i1_valid), .i1_data(i1_data), .i1_ready(i1_ready),
    .sel(sel), .y_valid(y_valid), .y(y), .y_ready(y_ready)
  );

  always #5 clk = ~clk;

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    i0_valid = 1'b0;
    i1_valid = 1'b0;
    y_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    i0_valid = 1'b1; i0_data = 8'hF0;
    i1_valid = 1'b1; i1_data = 8'h0F;
    y_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y_valid !== 1'b0 || y !== 8'h00 || sel !== 1'b0) begin
      errors++;
      $display("FAIL reset_regs: y_valid=%b y=%h sel=%b want 0 00 0",
               y_valid, y, sel);
    end
    checks++;
    if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
      errors++;
      $display("FAIL reset_ready: i0_ready=%b i1_ready=%b want 0 0",
               i0_ready, i1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    i0_valid = 1'b0;
    i1_valid = 1'b0;
    y_ready = 1'b0;
  endtask

  task automatic test_single();
    logic [7:0] words [2];
    words[0] = 8'hA5;
    words[1] = 8'h3C;
    do_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      i0_valid = 1'b1; i0_data = words[k];
      y_ready = 1'b1;
      #1;
      checks++;
      if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
        errors++;
        $display("FAIL single_ready[%0d]: i0=%b i1=%b want 1 0",
                 k, i0_ready, i1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (y !== words[k] || sel !== 1'b0 || y_valid !== 1'b1) begin
        errors++;
        $display("FAIL single_out[%0d]: y=%h sel=%b v=%b want %h 0 1",
                 k, y, sel, y_valid, words[k]);
      end
    end
    @(negedge clk);
    i0_valid = 1'b0;
    @(posedge clk); #1;
    checks++;
    if (y_valid !== 1'b0) begin
      errors++;
      $display("FAIL single_drain: y_valid=%b want 0", y_valid);
    end
  endtask

  task automatic test_contention();
    int n0 = 0;
    int n1 = 0;
    logic exp_sel;
    logic [7:0] exp_y;
    do_reset();
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      i0_valid = 1'b1; i0_data = 8'h10 + 8'(k);
      i1_valid = 1'b1; i1_data = 8'h20 + 8'(k);
      y_ready = 1'b1;
      exp_sel = ((k / BURST) % 2) == 1;
      exp_y = exp_sel ? 8'h20 + 8'(k) : 8'h10 + 8'(k);
      @(posedge clk); #1;
      checks++;
      if (sel !== exp_sel || y !== exp_y) begin
        errors++;
        $display("FAIL contention[%0d]: sel=%b y=%h want %b %h",
                 k, sel, y, exp_sel, exp_y);
      end
      if (sel === 1'b0) n0++;
      else n1++;
    end
    checks++;
    if (n0 != 4 || n1 != 4) begin
      errors++;
      $display("FAIL contention_share: n0=%0d n1=%0d want 4 4", n0, n1);
    end
    @(negedge clk);
    i0_valid = 1'b0;
    i1_valid = 1'b0;
  endtask

  task automatic test_backpressure();
    do_reset();
    @(negedge clk);
    i0_valid = 1'b1; i0_data = 8'h11;
    y_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y !== 8'h11 || y_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_load: y=%h v=%b want 11 1", y, y_valid);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      i0_valid = 1'b1; i0_data = 8'h22;
      i1_valid = 1'b1; i1_data = 8'h33;
      y_ready = 1'b0;
      #1;
      checks++;
      if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
        errors++;
        $display("FAIL bp_ready[%0d]: i0=%b i1=%b want 0 0",
                 k, i0_ready, i1_ready);
      end
      @(posedge clk); #1;
      checks++;
      if (y !== 8'h11 || sel !== 1'b0 || y_valid !== 1'b1) begin
        errors++;
        $display("FAIL bp_hold[%0d]: y=%h sel=%b v=%b want 11 0 1",
                 k, y, sel, y_valid);
      end
    end
    @(negedge clk);
    y_ready = 1'b1;
    #1;
    checks++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      errors++;
      $display("FAIL bp_release_ready: i0=%b i1=%b want 1 0",
               i0_ready, i1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 8'h22 || sel !== 1'b0 || y_valid !== 1'b1) begin
      errors++;
      $display("FAIL bp_release: y=%h sel=%b v=%b want 22 0 1",
               y, sel, y_valid);
    end
    @(negedge clk);
    i0_valid = 1'b0;
    i1_valid = 1'b0;
  endtask

  task automatic test_idle_break();
    do_reset();
    @(negedge clk);
    i1_valid = 1'b1; i1_data = 8'h55;
    y_ready = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (y !== 8'h55 || sel !== 1'b1) begin
      errors++;
      $display("FAIL idle_first: y=%h sel=%b want 55 1", y, sel);
    end
    @(negedge clk);
    i1_valid = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    i0_valid = 1'b1; i0_data = 8'h66;
    i1_valid = 1'b1; i1_data = 8'h77;
    #1;
    checks++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      errors++;
      $display("FAIL idle_break_ready: i0=%b i1=%b want 1 0",
               i0_ready, i1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (y !== 8'h66 || sel !== 1'b0) begin
      errors++;
      $display("FAIL idle_break_out: y=%h sel=%b want 66 0", y, sel);
    end
    @(negedge clk);
    i0_valid = 1'b0;
    i1_valid = 1'b0;
  endtask

  task automatic test_async_reset();
    do_reset();
    @(negedge clk);
    i0_valid = 1'b1; i0_data = 8'h7E;
    i1_valid = 1'b1; i1_data = 8'h01;
    y_ready = 1'b1;
    @(posedge clk); #1;
    @(negedge clk);
    y_ready = 1'b0;
    #2;
    checks++;
    if (y !== 8'h7E || y_valid !== 1'b1) begin
      errors++;
      $display("FAIL areset_pre: y=%h v=%b want 7e 1", y, y_valid);
    end
    rst = 1'b1;
    #1;
    checks++;
    if (y_valid !== 1'b0 || y !== 8'h00) begin
      errors++;
      $display("FAIL areset_now: y_valid=%b y=%h want 0 00", y_valid, y);
    end
    checks++;
    if (i0_ready !== 1'b0 || i1_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_ready: i0=%b i1=%b want 0 0",
               i0_ready, i1_ready);
    end
    @(negedge clk);
    rst = 1'b0;
    y_ready = 1'b1;
    #1;
    checks++;
    if (i0_ready !== 1'b1 || i1_ready !== 1'b0) begin
      errors++;
      $display("FAIL areset_first_grant: i0=%b i1=%b want 1 0",
               i0_ready, i1_ready);
    end
    @(posedge clk); #1;
    checks++;
    if (sel !== 1'b0 || y !== 8'h7E) begin
      errors++;
      $display("FAIL areset_first_out: sel=%b y=%h want 0 7e", sel, y);
    end
    @(negedge clk);
    i0_valid = 1'b0;
    i1_valid = 1'b0;
  endtask

  // Reference: who owns the link is decided from the run of consecutive
  // grants (run_len) and who held it last; the output register is a queue of depth 1.
  task automatic test_random();
    logic [7:0] cur [2];
    logic       v [2];
    logic [7:0] held [$];
    logic       held_src [$];
    logic       prev_owner;
    int         run_len;
    logic       took [2];
    logic       rdy;
    logic       can_load;
    int         g;
    logic       exp_r0;
    logic       exp_r1;
    do_reset();
    prev_owner = 1'b1;
    run_len = 0;
    for (int s = 0; s < 2; s++) begin
      v[s] = 1'b0;
      cur[s] = 8'($urandom);
      took[s] = 1'b0;
    end
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      for (int s = 0; s < 2; s++) begin
        if (took[s] || !v[s]) begin
          if (took[s]) cur[s] = 8'($urandom);
          v[s] = ($urandom % 4) != 0;
        end else if (($urandom % 8) == 0) begin
          v[s] = 1'b0;
        end
      end
      rdy = ($urandom % 4) != 0;
      i0_valid = v[0]; i0_data = cur[0];
      i1_valid = v[1]; i1_data = cur[1];
      y_ready = rdy;
      can_load = (held.size() == 0) || rdy;
      g = -1;
      if (can_load && (v[0] || v[1])) begin
        if (v[0] && v[1]) begin
          if (run_len == 0 || run_len >= BURST) g = prev_owner ? 0 : 1;
          else g = prev_owner ? 1 : 0;
        end else begin
          g = v[0] ? 0 : 1;
        end
      end
      exp_r0 = (g == 0);
      exp_r1 = (g == 1);
      #1;
      checks++;
      if (i0_ready !== exp_r0 || i1_ready !== exp_r1) begin
        errors++;
        $display("FAIL rand_ready[%0d]: i0=%b i1=%b want %b %b",
                 k, i0_ready, i1_ready, exp_r0, exp_r1);
      end
      @(posedge clk); #1;
      took[0] = (g == 0);
      took[1] = (g == 1);
      if (can_load && held.size() != 0) begin
        void'(held.pop_front());
        void'(held_src.pop_front());
      end
      if (g >= 0) begin
        held.push_back(cur[g]);
        held_src.push_back(g == 1);
        if (run_len > 0 && prev_owner == (g == 1))
          run_len = (run_len + 1 > BURST) ? BURST : run_len + 1;
        else
          run_len = 1;
        prev_owner = (g == 1);
      end else if (can_load) begin
        run_len = 0;
      end
      checks++;
      if (y_valid !== (held.size() != 0)) begin
        errors++;
        $display("FAIL rand_valid[%0d]: y_valid=%b want %b",
                 k, y_valid, held.size() != 0);
      end else if (held.size() != 0) begin
        checks++;
        if (y !== held[0] || sel !== held_src[0]) begin
          errors++;
          $display("FAIL rand_out[%0d]: y=%h sel=%b want %h %b",
                   k, y, sel, held[0], held_src[0]);
        end
      end
    end
    @(negedge clk);
    i0_valid = 1'b0;
    i1_valid = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_idle_break();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
